// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl
// Sequences a W-bit add/subtract (W = SLICE*NSLICE) through one external
// SLICE-bit adder. It processes one slice per clock, from least significant
// to most significant, and carries between slices in a register.
//
// Ports
//   clock, reset         rising-edge clock; asynchronous active-low reset
//   in_valid/in_ready    request handshake
//   in_a, in_b, in_sub   operands and operation (0 = A+B, 1 = A-B)
//   add_a/add_b/add_cin  drive to the external slice adder (zero outside RUN)
//   add_sum/add_cout     combinational return from the slice adder
//   out_valid/out_ready  result handshake
//   out_sum/out_cout     result, final carry (1 = no borrow on subtract)
//   out_ovf              signed two's-complement overflow
//   busy                 transaction in progress (RUN or DONE)
//
// state | meaning
// IDLE  | waiting for a request; in_ready high once out of reset
// RUN   | one slice per cycle through the external adder, idx = current slice
// DONE  | result held on outputs until out_ready
module adder_seq_ctrl #(
  parameter int SLICE  = 8,
  parameter int NSLICE = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLICE*NSLICE-1:0]   in_a,
  input  logic [SLICE*NSLICE-1:0]   in_b,
  input  logic                      in_sub,
  output logic [SLICE-1:0]          add_a,
  output logic [SLICE-1:0]          add_b,
  output logic                      add_cin,
  input  logic [SLICE-1:0]          add_sum,
  input  logic                      add_cout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SLICE*NSLICE-1:0]   out_sum,
  output logic                      out_cout,
  output logic                      out_ovf,
  output logic                      busy
);

  localparam int W  = SLICE * NSLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic            sub_q, carry_q, cout_q, ovf_q;
  logic            ready_q;
  logic [IW-1:0]   idx;
  logic            accept, last, msb_carry;
  int              slice_base;

  // ready_q keeps in_ready low while reset is asserted and releases it on
  // the first clock edge after reset deasserts.
  assign accept     = (state == IDLE) && ready_q && in_valid;
  assign last       = (idx == IDX_LAST);
  assign slice_base = int'(idx) * SLICE;
  // Carry into the slice MSB can be recovered from the sum bit.
  assign msb_carry  = add_a[SLICE-1] ^ add_b[SLICE-1] ^ add_sum[SLICE-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        add_a   = a_q[slice_base +: SLICE];
        add_b   = b_q[slice_base +: SLICE] ^ {SLICE{sub_q}};
        add_cin = (idx == '0) ? sub_q : carry_q;
        if (last) state_nxt = DONE;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx     <= '0;
    end else begin
      ready_q <= 1'b1;
      if (accept) begin
        a_q     <= in_a;
        b_q     <= in_b;
        sub_q   <= in_sub;
        sum_q   <= '0;
        carry_q <= 1'b0;
        cout_q  <= 1'b0;
        ovf_q   <= 1'b0;
        idx     <= '0;
      end else if (state == RUN) begin
        sum_q[slice_base +: SLICE] <= add_sum;
        carry_q                    <= add_cout;
        if (last) begin
          idx    <= '0;
          cout_q <= add_cout;
          ovf_q  <= msb_carry ^ add_cout;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

  assign in_ready  = (state == IDLE) && ready_q;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Testbench for adder_seq_ctrl: directed vector table, hand-written
// back-pressure and reset-abort sequences, then random operands checked
// against plain-arithmetic expectations.
module tb_adder_seq_ctrl;
  localparam int SLICE = 8, NSLICE = 4, W = 32;

  logic clock = 1'b0, reset = 1'b0;
  logic in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic in_ready, add_cin, add_cout, out_valid, out_cout, out_ovf, busy;
  logic [SLICE-1:0] add_a, add_b, add_sum;
  logic [W-1:0] out_sum;

  int n_checks = 0, n_fail = 0;

  always #5 clock = ~clock;

  // Behavioural external slice adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{SLICE{1'b0}}, add_cin};

  adder_seq_ctrl #(.SLICE(SLICE), .NSLICE(NSLICE)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic on unsigned and signed values.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] s, output logic c, output logic o);
    longint unsigned ua, ub, full;
    longint sa, sb, sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!sub) begin
      full = ua + ub;
      s = full[W-1:0];
      c = (full >= 64'h1_0000_0000);
      sr = sa + sb;
    end else begin
      s = a - b;
      c = (ua >= ub);
      sr = sa - sb;
    end
    o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endtask

  task automatic check_idle_adder(input string tag);
    check({tag, " add_a"}, add_a, 0);
    check({tag, " add_b"}, add_b, 0);
    check({tag, " add_cin"}, add_cin, 0);
  endtask

  // Complete one transaction. hold = cycles out_ready stays low in DONE,
  // with in_valid driven high to show it is ignored (including through the
  // handshake edge).
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input int hold, input string tag);
    logic [W-1:0] es;
    logic ec, eo;
    logic [7:0] eb;
    int cnt;
    model(a, b, sub, es, ec, eo);
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    check({tag, " ready before request"}, in_ready, 1);
    if (!in_ready) return;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; in_a = ~a; in_b = b ^ 32'h5a5a_a5a5; in_sub = ~sub;
    eb = sub ? ~b[7:0] : b[7:0];
    check({tag, " slice0 add_a"}, add_a, a[7:0]);
    check({tag, " slice0 add_b"}, add_b, eb);
    check({tag, " slice0 add_cin"}, add_cin, sub);
    check({tag, " in_ready in RUN"}, in_ready, 0);
    check({tag, " busy in RUN"}, busy, 1);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clock);
      cnt++;
      @(negedge clock);
    end
    check({tag, " latency"}, cnt, NSLICE);
    check({tag, " out_sum"}, out_sum, es);
    check({tag, " out_cout"}, out_cout, ec);
    check({tag, " out_ovf"}, out_ovf, eo);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom);
      @(posedge clock);
      @(negedge clock);
      check({tag, " hold out_valid"}, out_valid, 1);
      check({tag, " hold in_ready"}, in_ready, 0);
      check({tag, " hold out_sum"}, out_sum, es);
      check({tag, " hold out_cout"}, out_cout, ec);
      check({tag, " hold out_ovf"}, out_ovf, eo);
      check_idle_adder({tag, " hold"});
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, out_valid, 0);
    if (hold > 0) begin
      check({tag, " no accept in handshake cycle"}, busy, 0);
      check({tag, " in_ready after handshake"}, in_ready, 1);
    end
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];
  logic [W-1:0] ra, rb;
  logic [W-1:0] es;
  logic ec, eo;
  int seen;

  initial begin
    vecs.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
    vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0});

    // Reset state.
    #1;
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset out_sum", out_sum, 0);
    check_idle_adder("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    check("in_ready before first edge", in_ready, 0);
    @(posedge clock);
    @(negedge clock);
    check("in_ready after reset release", in_ready, 1);
    check_idle_adder("idle");

    // Directed vectors: the table values must agree with the model as well.
    foreach (vecs[i]) begin
      model(vecs[i].a, vecs[i].b, vecs[i].sub, es, ec, eo);
      check($sformatf("vec%0d model sum", i), es, vecs[i].sum);
      check($sformatf("vec%0d model cout", i), ec, vecs[i].cout);
      check($sformatf("vec%0d model ovf", i), eo, vecs[i].ovf);
      run_txn(vecs[i].a, vecs[i].b, vecs[i].sub, 0, $sformatf("vec%0d", i));
    end

    // Back-pressure in DONE, then the follow-on request.
    run_txn(32'h1234_5678, 32'h1111_1111, 1'b0, 3, "hold");
    run_txn(32'hCAFE_0000, 32'h0000_BABE, 1'b1, 0, "after hold");

    // Reset at RUN idx=2 abandons the transaction.
    in_valid = 1'b1; in_a = 32'h1122_3344; in_b = 32'h5566_7788; in_sub = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    check("abort idx2 add_a", add_a, 8'h22);
    reset = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort out_sum", out_sum, 0);
    check("abort out_cout", out_cout, 0);
    check("abort out_ovf", out_ovf, 0);
    check("abort busy", busy, 0);
    check("abort in_ready", in_ready, 0);
    check_idle_adder("abort");
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (out_valid) seen++;
    end
    check("abort no result emitted", seen, 0);
    run_txn(32'h0001_0000, 32'h0001_0000, 1'b0, 0, "post-abort");

    // Random operands against the model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 1) rb = ra;
      if (i % 8 == 3) ra = 32'h7FFF_FFFF;
      if (i % 8 == 5) rb = 32'hFFFF_FFFF;
      run_txn(ra, rb, 1'($urandom), (i % 10 == 7) ? 2 : 0, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 Parameter: SLICE, default 8, width in bits of the shared slice adder.
REQ-002 Parameter: NSLICE, default 4, slices per operand; operand width W = SLICE*NSLICE (default 32).
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately, independent of clock.
REQ-005 in_valid  input  1  request operands present.
REQ-006 in_ready  output  1  controller can accept a request.
REQ-007 in_a  input  W  operand A.
REQ-008 in_b  input  W  operand B.
REQ-009 in_sub  input  1  0 = A+B, 1 = A-B.
REQ-010 add_a  output  SLICE  slice operand A to the external slice adder.
REQ-011 add_b  output  SLICE  slice operand B to the adder, already inverted for subtract.
REQ-012 add_cin  output  1  adder carry-in.
REQ-013 add_sum  input  SLICE  adder sum, combinational from add_a/add_b/add_cin.
REQ-014 add_cout  input  1  adder carry-out, combinational.
REQ-015 out_valid  output  1  result present.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 out_sum  output  W  result.
REQ-018 out_cout  output  1  final carry-out; for subtract, 1 = no borrow.
REQ-019 out_ovf  output  1  signed two's-complement overflow.
REQ-020 busy  output  1  high in RUN or DONE.

Function
REQ-021 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-022 IDLE: in_ready=1; on in_valid=1 at an edge, register in_a, in_b, in_sub, clear slice index idx to 0, clear result register, go to RUN.
REQ-023 RUN: in_ready=0; add_a = A slice idx; add_b = B slice idx, bitwise inverted when sub=1; add_cin = sub when idx=0, else the registered carry.
REQ-024 Each RUN edge SHALL write add_sum into result slice idx, register add_cout as carry, and increment idx.
REQ-025 At the edge where idx = NSLICE-1, the FSM SHALL go to DONE, capture out_cout = add_cout, and capture out_ovf = carry into slice MSB XOR add_cout; carry into the MSB is add_a[SLICE-1] ^ add_b[SLICE-1] ^ add_sum[SLICE-1].
REQ-026 Latency: with acceptance at edge k, out_valid SHALL be 1 from edge k+NSLICE (4 for default).
REQ-027 DONE: out_valid=1; out_sum, out_cout and out_ovf stable until handshake; in_ready=0; on out_ready=1 go to IDLE, out_valid=0 next cycle.
REQ-028 No overlap: a new request SHALL NOT be accepted in the DONE-to-IDLE handshake cycle; it is accepted from IDLE at the earliest one edge later.
REQ-029 Outside RUN, add_a, add_b and add_cin SHALL be driven 0.
REQ-030 in_valid with in_ready=0 SHALL be ignored; operand inputs are sampled only at acceptance, and changes afterwards SHALL have no effect.
REQ-031 Arithmetic is modulo 2^W; idx width is ceil(log2(NSLICE)), minimum 1, and idx SHALL never exceed NSLICE-1.

Reset
REQ-032 reset=0 SHALL force, asynchronously: state=IDLE, idx=0, carry=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, and all add_* outputs=0.
REQ-033 in_ready SHALL read 0 while reset=0 and 1 from the first cycle after reset deasserts.
REQ-034 Reset asserted mid-RUN or in DONE SHALL abandon the transaction with no result emitted; the next request SHALL complete correctly.

Verification
REQ-035 0x000000FF + 0x00000001 -> out_sum 0x00000100, cout 0, ovf 0, out_valid exactly 4 edges after acceptance.
REQ-036 0xFFFFFFFF + 0x00000001 -> out_sum 0x00000000, cout 1, ovf 0.
REQ-037 0x7FFFFFFF + 0x00000001 -> out_sum 0x80000000, cout 0, ovf 1.
REQ-038 sub 0x00000005 - 0x00000007 -> out_sum 0xFFFFFFFE, cout 0 (borrow), ovf 0; add_cin=1 in slice 0 and add_b=0xF8 in slice 0.
REQ-039 out_ready held 0 for 3 cycles in DONE -> outputs stable, in_ready 0, in_valid pulses ignored; out_ready=1 -> IDLE, then the next request is accepted.
REQ-040 reset pulsed at RUN idx=2 -> all outputs 0 immediately, no out_valid; a following 0x00010000 + 0x00010000 yields 0x00020000.
